// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared FSM states, standard truth tables and width helper for the gate BIST checker
package gate_bist_pkg;
  typedef enum logic {ST_IDLE, ST_STEP} state_t;
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_XOR2 = 4'b0110;
  localparam logic [3:0] TT_NOR2 = 4'b0001;
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/gate_bist_checker_if.sv
// gate_bist_checker_if: host/gate bundle (start, resp in; stim, busy, done, pass, err_cnt, first_fail_vec/valid out of the checker)
interface gate_bist_checker_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic             start;
  logic             resp;
  logic [N_IN-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [N_IN-1:0]  first_fail_vec;
  logic             first_fail_valid;
  modport master (output start, resp, input stim, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid);
  modport slave  (input start, resp, output stim, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: WIDTH-bit up counter (clk, rst_n sync active-low, clr, inc -> q), clear wins, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else q <= clr ? '0 : (inc && q != '1) ? q + WIDTH'(1) : q;
  end
endmodule

// File: rtl/gate_bist_checker.sv
// gate_bist_checker: sweeps all stim vectors of an N_IN-input gate, samples resp after SETTLE cycles, compares to TRUTH (ports: clk, rst_n, bus slave)
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int                          N_IN   = 2,
  parameter logic [tt_width(N_IN)-1:0]   TRUTH  = TT_OR2,
  parameter int                          SETTLE = 1,
  parameter int                          ERR_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  gate_bist_checker_if.slave bus
);
  state_t          state, state_d;
  logic [3:0]      wait_cnt, wait_d;
  logic [N_IN-1:0] stim_d, ffv_d;
  logic            busy_d, done_d, pass_d, ffvalid_d, clr, inc, miss;
  assign miss = bus.resp != TRUTH[bus.stim];
  always_comb begin
    state_d   = state;
    wait_d    = wait_cnt;
    stim_d    = bus.stim;
    busy_d    = bus.busy;
    done_d    = 1'b0;
    pass_d    = bus.pass;
    ffv_d     = bus.first_fail_vec;
    ffvalid_d = bus.first_fail_valid;
    clr       = 1'b0;
    inc       = 1'b0;
    if (state == ST_IDLE) begin
      if (bus.start) begin
        state_d   = ST_STEP;
        wait_d    = 4'(SETTLE);
        stim_d    = '0;
        busy_d    = 1'b1;
        pass_d    = 1'b0;
        ffv_d     = '0;
        ffvalid_d = 1'b0;
        clr       = 1'b1;
      end
    end else if (wait_cnt != 4'd0) begin
      wait_d = wait_cnt - 4'd1;
    end else begin
      inc = miss;
      if (miss && !bus.first_fail_valid) begin
        ffv_d     = bus.stim;
        ffvalid_d = 1'b1;
      end
      if (bus.stim != '1) begin
        stim_d = bus.stim + N_IN'(1);
        wait_d = 4'(SETTLE);
      end else begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = bus.err_cnt == '0 && !miss;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      wait_cnt             <= '0;
      bus.stim             <= '0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.pass             <= 1'b0;
      bus.first_fail_vec   <= '0;
      bus.first_fail_valid <= 1'b0;
    end else begin
      state                <= state_d;
      wait_cnt             <= wait_d;
      bus.stim             <= stim_d;
      bus.busy             <= busy_d;
      bus.done             <= done_d;
      bus.pass             <= pass_d;
      bus.first_fail_vec   <= ffv_d;
      bus.first_fail_valid <= ffvalid_d;
    end
  end
  sat_counter #(.WIDTH(ERR_W)) u_err (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (inc),
    .q    (bus.err_cnt)
  );
endmodule

// File: tb/tb_gate_bist_checker.sv
// tb_gate_bist_checker: table-driven gate-model runs plus reset, held-start and saturation corner cases
module tb_gate_bist_checker;
  import gate_bist_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  gate_bist_checker_if #(.N_IN(2), .ERR_W(8)) b1 ();
  gate_bist_checker_if #(.N_IN(2), .ERR_W(1)) b2 ();
  gate_bist_checker #(.N_IN(2), .TRUTH(TT_OR2), .SETTLE(1), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  gate_bist_checker #(.N_IN(2), .TRUTH(TT_OR2), .SETTLE(0), .ERR_W(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );
  always_comb begin
    b1.resp = 1'b0;
    case (mode)
      0: b1.resp = |b1.stim;
      1: b1.resp = &b1.stim;
      2: b1.resp = 1'b0;
      3: b1.resp = 1'b1;
      4: b1.resp = ^b1.stim;
      default: b1.resp = ~|b1.stim;
    endcase
  end
  assign b2.resp = 1'b0;
  typedef struct {
    string nm;
    int    mode;
    int    err;
    int    ffv;
    int    ffvalid;
    int    pass;
  } vec_t;
  vec_t tv[6];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic run_one(input string nm, input int err, input int ffv, input int ffvalid, input int pss);
    int k;
    int stim_ok;
    stim_ok = 1;
    @(negedge clk) b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    chk({nm, " busy_on_accept"}, int'(b1.busy), 1);
    k = 0;
    while (!b1.done && k < 20) begin
      if (k < 8 && int'(b1.stim) != k / 2) stim_ok = 0;
      @(posedge clk);
      #1 k++;
    end
    chk({nm, " done_latency"}, k, 8);
    chk({nm, " stim_sequence"}, stim_ok, 1);
    chk({nm, " err_cnt"}, int'(b1.err_cnt), err);
    chk({nm, " first_fail_vec"}, int'(b1.first_fail_vec), ffv);
    chk({nm, " first_fail_valid"}, int'(b1.first_fail_valid), ffvalid);
    chk({nm, " pass"}, int'(b1.pass), pss);
    chk({nm, " busy_at_done"}, int'(b1.busy), 0);
    @(posedge clk);
    #1 chk({nm, " done_one_cycle"}, int'(b1.done), 0);
    chk({nm, " pass_held"}, int'(b1.pass), pss);
  endtask
  initial begin
    int k;
    int no_done;
    int last;
    int pulses;
    tv[0] = '{"or_model",   0, 0, 0, 0, 1};
    tv[1] = '{"and_model",  1, 2, 1, 1, 0};
    tv[2] = '{"tie0",       2, 3, 1, 1, 0};
    tv[3] = '{"tie1",       3, 1, 0, 1, 0};
    tv[4] = '{"xor_model",  4, 1, 3, 1, 0};
    tv[5] = '{"nor_model",  5, 4, 0, 1, 0};
    b1.start = 1'b0;
    b2.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(b1.busy), 0);
    chk("reset done", int'(b1.done), 0);
    chk("reset pass", int'(b1.pass), 0);
    chk("reset stim", int'(b1.stim), 0);
    chk("reset err_cnt", int'(b1.err_cnt), 0);
    chk("reset ffv", int'(b1.first_fail_vec), 0);
    chk("reset ffvalid", int'(b1.first_fail_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mode = tv[i].mode;
      run_one(tv[i].nm, tv[i].err, tv[i].ffv, tv[i].ffvalid, tv[i].pass);
    end
    mode = 2;
    @(negedge clk) b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("midrun err_before_reset", int'(b1.err_cnt), 1);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun_reset busy", int'(b1.busy), 0);
    chk("midrun_reset stim", int'(b1.stim), 0);
    chk("midrun_reset err_cnt", int'(b1.err_cnt), 0);
    chk("midrun_reset ffvalid", int'(b1.first_fail_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    no_done = 1;
    repeat (12) begin
      @(posedge clk);
      #1 if (b1.done || b1.busy) no_done = 0;
    end
    chk("midrun_reset no_done", no_done, 1);
    mode = 0;
    run_one("after_reset_or", 0, 0, 0, 1);
    mode = 3;
    last = -1;
    pulses = 0;
    @(negedge clk) b1.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (last >= 0 && c == last + 1) begin
        chk("held reaccept err_clear", int'(b1.err_cnt), 0);
        chk("held reaccept busy", int'(b1.busy), 1);
      end
      if (b1.done) begin
        if (last >= 0) chk("held done_period", c - last, 9);
        chk("held err_cnt", int'(b1.err_cnt), 1);
        last = c;
        pulses++;
      end
    end
    chk("held done_pulses", pulses, 4);
    @(negedge clk) b1.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("held drained busy", int'(b1.busy), 0);
    @(negedge clk) b2.start = 1'b1;
    @(posedge clk);
    #1 b2.start = 1'b0;
    k = 0;
    while (!b2.done && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    chk("sat done_latency", k, 4);
    chk("sat err_cnt", int'(b2.err_cnt), 1);
    chk("sat pass", int'(b2.pass), 0);
    chk("sat first_fail_vec", int'(b2.first_fail_vec), 1);
    chk("sat first_fail_valid", int'(b2.first_fail_valid), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
